// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over valid/ready, packs big-endian
// 32-bit words into the instruction memory, and holds the CPU in reset
// until a complete program has been written.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; cpu_rst follows the loaded flag
// S_LEN_HI | accepting the high byte of the word count
// S_LEN_LO | accepting the low byte; the range check happens on this byte
// S_DATA   | accepting instruction bytes, writing one word per four bytes
// S_FINISH | last word strobed; release the CPU and pulse done
// S_ERR    | load aborted; raise error, keep the CPU in reset
module imem_loader #(
    parameter int ADDR_WIDTH     = 7,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Idle-gap timer is a down-counter reloaded on every transfer; it trips
    // when an idle cycle finds it already at zero.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD =
        (TIMEOUT_CYCLES > 1) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FINISH,
        S_ERR
    } state_t;

    state_t                state, state_n;
    logic                  rx_ready_n, imem_we_n, cpu_rst_n, busy_n, done_n, error_n;
    logic                  loaded, loaded_n;
    logic [ADDR_WIDTH-1:0] imem_addr_n;
    logic [31:0]           imem_wdata_n;
    logic [7:0]            len_hi, len_hi_n;
    logic [15:0]           remaining, remaining_n;
    logic [1:0]            byte_idx, byte_idx_n;
    logic [23:0]           word_buf, word_buf_n;
    logic [TW-1:0]         tmo_cnt, tmo_cnt_n;
    logic                  xfer, tmo_hit, len_bad;
    logic [15:0]           len_word;

    assign xfer     = rx_valid && rx_ready;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && !xfer && (tmo_cnt == '0);
    assign len_word = {len_hi, rx_data};
    assign len_bad  = (len_word == 16'd0) ||
                      ((32'(len_word) + 32'(BASE_ADDR)) > 32'(DEPTH));

    // Next-state and next-output computation; every output is a register.
    always_comb begin
        state_n      = state;
        imem_we_n    = 1'b0;
        done_n       = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_rst_n    = cpu_rst;
        busy_n       = busy;
        error_n      = error;
        loaded_n     = loaded;
        len_hi_n     = len_hi;
        remaining_n  = remaining;
        byte_idx_n   = byte_idx;
        word_buf_n   = word_buf;
        tmo_cnt_n    = tmo_cnt;

        // Address advances the cycle after each strobe.
        if (imem_we) begin
            imem_addr_n = imem_addr + 1'b1;
        end

        if (xfer) begin
            tmo_cnt_n = TMO_LOAD;
        end else if (state == S_LEN_HI || state == S_LEN_LO || state == S_DATA) begin
            tmo_cnt_n = tmo_cnt - 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_LEN_HI;
                    busy_n      = 1'b1;
                    cpu_rst_n   = 1'b1;
                    error_n     = 1'b0;
                    imem_addr_n = BASE;
                    byte_idx_n  = 2'd0;
                    tmo_cnt_n   = TMO_LOAD;
                end else begin
                    cpu_rst_n = ~loaded;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_n = rx_data;
                    state_n  = S_LEN_LO;
                end else if (tmo_hit) begin
                    state_n = S_ERR;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_n = S_ERR;
                    end else begin
                        remaining_n = len_word;
                        state_n     = S_DATA;
                    end
                end else if (tmo_hit) begin
                    state_n = S_ERR;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_idx_n = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf_n[23:16] = rx_data;
                        2'd1: word_buf_n[15:8]  = rx_data;
                        2'd2: word_buf_n[7:0]   = rx_data;
                        default: begin
                            imem_we_n    = 1'b1;
                            imem_wdata_n = {word_buf, rx_data};
                            if (remaining == 16'd1) begin
                                state_n = S_FINISH;
                            end else begin
                                remaining_n = remaining - 16'd1;
                            end
                        end
                    endcase
                end else if (tmo_hit) begin
                    state_n = S_ERR;
                end
            end
            S_FINISH: begin
                done_n    = 1'b1;
                busy_n    = 1'b0;
                cpu_rst_n = 1'b0;
                loaded_n  = 1'b1;
                state_n   = S_IDLE;
            end
            S_ERR: begin
                error_n   = 1'b1;
                busy_n    = 1'b0;
                loaded_n  = 1'b0;
                cpu_rst_n = 1'b1;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        rx_ready_n = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                     (state_n == S_DATA);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            loaded     <= 1'b0;
            len_hi     <= 8'd0;
            remaining  <= 16'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_n;
            rx_ready   <= rx_ready_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_rst    <= cpu_rst_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            loaded     <= loaded_n;
            len_hi     <= len_hi_n;
            remaining  <= remaining_n;
            byte_idx   <= byte_idx_n;
            word_buf   <= word_buf_n;
            tmo_cnt    <= tmo_cnt_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 with a 16-cycle timeout,
// base 120 with the timeout disabled), a table of load scenarios, a write
// scoreboard, and hand-written reset/stall sequences.
module tb_imem_loader;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start_v, rx_valid_v, rx_ready_v, imem_we_v;
    logic [1:0]       cpu_rst_v, busy_v, done_v, error_v;
    logic [1:0][7:0]  rx_data_v;
    logic [1:0][6:0]  imem_addr_v;
    logic [1:0][31:0] imem_wdata_v;

    int checks   = 0;
    int failures = 0;
    int wr_cnt [2];
    int done_cnt [2];
    logic [1:0] prev_we, prev_cpu_rst;
    logic [38:0] q0 [$];
    logic [38:0] q1 [$];

    typedef struct {
        int          dut;
        int          n;
        int          data_bytes;
        int          gap;
        bit          exp_err;
        int          exp_writes;
        logic [95:0] words;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(7), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .rx_valid(rx_valid_v[0]),
        .rx_data(rx_data_v[0]), .rx_ready(rx_ready_v[0]), .imem_we(imem_we_v[0]),
        .imem_addr(imem_addr_v[0]), .imem_wdata(imem_wdata_v[0]),
        .cpu_rst(cpu_rst_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0])
    );

    imem_loader #(.ADDR_WIDTH(7), .BASE_ADDR(120), .TIMEOUT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .rx_valid(rx_valid_v[1]),
        .rx_data(rx_data_v[1]), .rx_ready(rx_ready_v[1]), .imem_we(imem_we_v[1]),
        .imem_addr(imem_addr_v[1]), .imem_wdata(imem_wdata_v[1]),
        .cpu_rst(cpu_rst_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1])
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] word_of(vec_t v, int k);
        if (k < 3) return v.words[95-32*k -: 32];
        return {k[7:0], 8'h5A, 8'(255 - k), 8'(k * 7)};
    endfunction

    task automatic push_exp(int d, logic [6:0] a, logic [31:0] w);
        if (d == 0) q0.push_back({a, w});
        else        q1.push_back({a, w});
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(int d, logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_valid_v[d] = 1'b1;
        rx_data_v[d]  = b;
        for (int i = 0; i < 64; i++) begin
            if (rx_ready_v[d]) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        rx_valid_v[d] = 1'b0;
        if (!ok) chk("rx_ready_wait", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start(int d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    task automatic wait_idle(int d);
        for (int i = 0; i < 100; i++) begin
            if (!busy_v[d]) break;
            tick();
        end
        chk("load_ends", 32'(busy_v[d]), 32'd0);
    endtask

    task automatic run_load(vec_t v);
        int          d, base, c;
        bit          valid;
        logic [31:0] w;
        d     = v.dut;
        base  = (d == 0) ? 0 : 120;
        valid = (v.n != 0) && (base + v.n <= 128);
        wr_cnt[d]   = 0;
        done_cnt[d] = 0;
        pulse_start(d);
        chk("start_busy", 32'(busy_v[d]), 32'd1);
        chk("start_cpu_rst", 32'(cpu_rst_v[d]), 32'd1);
        chk("start_clears_error", 32'(error_v[d]), 32'd0);
        send_byte(d, 8'(v.n >> 8));
        send_byte(d, 8'(v.n));
        for (int i = 0; i < v.data_bytes; i++) begin
            w = word_of(v, i / 4);
            if ((i % 4) == 3 && valid) push_exp(d, 7'(base + i / 4), w);
            send_byte(d, w[31-8*(i%4) -: 8]);
            repeat (v.gap) tick();
        end
        if (valid && v.data_bytes < 4 * v.n) begin
            c = 0;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (error_v[d]) begin
                    c = i;
                    break;
                end
            end
            checks++;
            if (c < 16 || c > 18) begin
                failures++;
                $display("FAIL timeout_delay: got %0d cycles expected 16..18", c);
            end
        end
        wait_idle(d);
        tick(2);
        chk("writes", 32'(wr_cnt[d]), 32'(v.exp_writes));
        chk("done_pulses", 32'(done_cnt[d]), v.exp_err ? 32'd0 : 32'd1);
        chk("error", 32'(error_v[d]), 32'(v.exp_err));
        chk("cpu_rst_after", 32'(cpu_rst_v[d]), 32'(v.exp_err));
        chk("rx_ready_after", 32'(rx_ready_v[d]), 32'd0);
        chk("queue_drained", (d == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
    endtask

    // Scoreboard: every write strobe must match the next expected entry.
    always @(negedge clk) begin
        logic [38:0] e;
        for (int d = 0; d < 2; d++) begin
            if (!rst && imem_we_v[d]) begin
                wr_cnt[d]++;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write dut%0d: addr %0h data %0h", d,
                             imem_addr_v[d], imem_wdata_v[d]);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("wr_addr", 32'(imem_addr_v[d]), 32'(e[38:32]));
                    chk("wr_data", imem_wdata_v[d], e[31:0]);
                    chk("wr_busy", 32'(busy_v[d]), 32'd1);
                end
            end
            if (!rst && done_v[d]) begin
                done_cnt[d]++;
                chk("done_timing", {29'd0, prev_we[d], prev_cpu_rst[d], cpu_rst_v[d]},
                    32'b110);
            end
            prev_we[d]      = imem_we_v[d];
            prev_cpu_rst[d] = cpu_rst_v[d];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1,   4,   0, 1'b0, 1,   {32'h8C250003, 64'd0}};
        vecs[1] = '{0, 3,   12,  1, 1'b0, 3,   {32'h00810020, 32'h8C250003, 32'h10E70007}};
        vecs[2] = '{0, 0,   0,   0, 1'b1, 0,   96'd0};
        vecs[3] = '{0, 129, 0,   0, 1'b1, 0,   96'd0};
        vecs[4] = '{1, 9,   0,   0, 1'b1, 0,   96'd0};
        vecs[5] = '{1, 8,   32,  0, 1'b0, 8,   {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF}};
        vecs[6] = '{0, 2,   5,   0, 1'b1, 1,   {32'h11223344, 32'h55667788, 32'd0}};
        vecs[7] = '{0, 128, 512, 0, 1'b0, 128, {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3}};

        rst          = 1'b1;
        start_v      = 2'b11;
        rx_valid_v   = 2'b00;
        rx_data_v    = '0;
        prev_we      = 2'b00;
        prev_cpu_rst = 2'b11;
        wr_cnt[0] = 0; wr_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
        tick(3);
        rst     = 1'b0;
        start_v = 2'b00;
        tick();
        chk("rst_rx_ready", 32'(rx_ready_v[0]), 32'd0);
        chk("rst_we", 32'(imem_we_v[0]), 32'd0);
        chk("rst_addr", 32'(imem_addr_v[0]), 32'd0);
        chk("rst_wdata", imem_wdata_v[0], 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst_v[0]), 32'd1);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_error", 32'(error_v[0]), 32'd0);
        chk("rst_addr_base120", 32'(imem_addr_v[1]), 32'd120);
        chk("rst_busy_dut1", 32'(busy_v[1]), 32'd0);

        for (int i = 0; i < 8; i++) run_load(vecs[i]);

        // Reset mid-load, with a start issued while busy.
        wr_cnt[0] = 0;
        pulse_start(0);
        send_byte(0, 8'h00);
        send_byte(0, 8'h03);
        push_exp(0, 7'd0, 32'h00810020);
        push_exp(0, 7'd1, 32'h8C250003);
        send_byte(0, 8'h00); send_byte(0, 8'h81); send_byte(0, 8'h00); send_byte(0, 8'h20);
        pulse_start(0);
        send_byte(0, 8'h8C); send_byte(0, 8'h25); send_byte(0, 8'h00); send_byte(0, 8'h03);
        send_byte(0, 8'h10); send_byte(0, 8'hE7);
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rx_ready", 32'(rx_ready_v[0]), 32'd0);
        chk("midrst_we", 32'(imem_we_v[0]), 32'd0);
        chk("midrst_addr", 32'(imem_addr_v[0]), 32'd0);
        chk("midrst_wdata", imem_wdata_v[0], 32'd0);
        chk("midrst_cpu_rst", 32'(cpu_rst_v[0]), 32'd1);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        chk("midrst_error", 32'(error_v[0]), 32'd0);
        tick(10);
        chk("midrst_writes", 32'(wr_cnt[0]), 32'd2);
        chk("midrst_cpu_rst_held", 32'(cpu_rst_v[0]), 32'd1);
        run_load(vecs[0]);

        // Disabled timeout: a long stall mid-word must not abort the load.
        wr_cnt[1] = 0;
        done_cnt[1] = 0;
        pulse_start(1);
        send_byte(1, 8'h00);
        send_byte(1, 8'h01);
        push_exp(1, 7'd120, 32'hCAFEF00D);
        send_byte(1, 8'hCA);
        send_byte(1, 8'hFE);
        tick(40);
        chk("stall_busy", 32'(busy_v[1]), 32'd1);
        chk("stall_error", 32'(error_v[1]), 32'd0);
        send_byte(1, 8'hF0);
        send_byte(1, 8'h0D);
        wait_idle(1);
        tick(2);
        chk("stall_writes", 32'(wr_cnt[1]), 32'd1);
        chk("stall_done", 32'(done_cnt[1]), 32'd1);
        chk("stall_cpu_rst", 32'(cpu_rst_v[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. It receives a byte stream over a valid/ready handshake from the host serial link.
- It assembles big-endian 32-bit instruction words and writes them sequentially into the instruction memory through a word-addressed write port.
- It holds the CPU in reset while loading, then releases it so the CPU fetches from word 0.
- It sits between the host link and the instruction memory/CPU reset, at the top level alongside the CPU.

Parameters:
- ADDR_WIDTH, 7, IMEM word-address width; DEPTH = 2**ADDR_WIDTH = 128 words.
- BASE_ADDR, 0, first word address written.
- TIMEOUT_CYCLES, 1000000, maximum cycles between accepted bytes during a load; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- rx_valid  in  1  byte available.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts the byte this cycle.
- imem_we  out  1  one-cycle IMEM write strobe.
- imem_addr  out  ADDR_WIDTH  IMEM word address.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  reset to the CPU; high while no valid program is loaded.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky flag: load aborted.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0. Internal `loaded`=0, state=IDLE.
- Byte transfer: a byte transfers on a cycle where rx_valid && rx_ready. rx_data is sampled only then.
- rx_ready is 1 in LEN_HI, LEN_LO and DATA, and 0 in every other state.
- States: IDLE, LEN_HI, LEN_LO, DATA, FINISH, ERR.
- IDLE:
  - start=1: go to LEN_HI, busy=1, cpu_rst=1, error=0, imem_addr=BASE_ADDR, byte index=0, timeout counter cleared.
  - Otherwise: cpu_rst = ~loaded.
- LEN_HI / LEN_LO: the two transferred bytes form the 16-bit word count N (high byte first).
- After LEN_LO:
  - If N==0 or BASE_ADDR+N > DEPTH, go to ERR.
  - Otherwise go to DATA with remaining count = N.
- DATA:
  - Byte k of each word (k=0..3) goes to bits [31-8k -: 8].
  - On the 4th byte, in the next cycle: imem_we=1, imem_wdata = assembled word, imem_addr = current word address.
  - The cycle after the strobe, imem_addr increments by 1. No wrap is possible because the range was checked.
  - rx_ready stays 1 during the strobe cycle, so back-to-back bytes sustain 1 word per 4 cycles.
  - When the strobe for the Nth word is issued, go to FINISH.
- FINISH (one cycle): done=1, busy=0, cpu_rst=0, loaded=1, then go to IDLE.
- Timeout: a counter increments each cycle in LEN_HI/LEN_LO/DATA without a transfer and clears on every transfer. Reaching TIMEOUT_CYCLES (when nonzero) goes to ERR.
- ERR (one cycle):
  - error=1 (sticky until next start or rst), busy=0, loaded=0, cpu_rst stays 1, then go to IDLE.
  - Words already written remain in IMEM.
  - A partial word is discarded and never written.
- start while busy is ignored.
- start in the same cycle as rst: rst wins.
- rst mid-load aborts immediately to reset values with no further imem_we. The partial program remains, but cpu_rst=1 because loaded=0.
- A new load after a successful one: cpu_rst rises the cycle after start and stays high until FINISH.

Test Plan:
- rst, then start; stream 00 01 8C 25 00 03 with no gaps -> exactly one imem_we with imem_addr=0, imem_wdata=32'h8C250003; done pulses 1 cycle later; cpu_rst 1→0 in the same cycle as done; rx_ready=0 afterwards.
- N=3, words 32'h00810020, 32'h8C250003, 32'h10E70007, with rx_valid toggled every other cycle -> writes to addresses 0, 1, 2 in order with exact data; busy=1 throughout; exactly one done pulse.
- Header 00 00 (N=0) -> error=1; no imem_we; cpu_rst remains 1; next start clears error.
- Header 00 81 (N=129 > 128) -> error; no writes. Also with BASE_ADDR=120 and N=9 -> error, and N=8 -> writes to addresses 120..127.
- TIMEOUT_CYCLES=16: send 00 02 plus 5 data bytes, then stall -> exactly one write (word 0), error asserts after 16 idle cycles, and the partial second word is not written.
- Assert rst after 2 of 3 words are written; also assert start while busy -> no further imem_we after reset, all outputs at reset values, and cpu_rst=1 until a new complete load. start during busy has no effect on the count or addresses.
